ll_window_engine: RTL and testbench
===================================

// Module: ll_window_engine
// PURPOSE
//  Parametrised line-length feature engine, successor to the fixed 5-window LL path.
//  - Per accepted sample: |x[n]-x[n-1]| is summed over WIN_LEN samples into one window sum.
//  - The last NUM_WIN window sums are held in a circular buffer.
//  - A running total (add newest, subtract oldest) is output once per window; no NUM_WIN-input adder.
//  - Sits between the sample front end and the feature controller; adds a sample handshake and a sync clear.
// PARAMETERS
//  IN_W     16  width of signed input sample
//  WIN_LEN  50  accepted samples per window (>=2)
//  NUM_WIN   5  windows in the running total (>=2)
//  ACC_W    derived localparam: IN_W+1+$clog2(WIN_LEN)   (23 at defaults)
//  OUT_W    derived localparam: ACC_W+$clog2(NUM_WIN)     (26 at defaults)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, ACTIVE-LOW
//  en          in   1      enable, active-low; high = freeze all state
//  clear       in   1      synchronous clear, active-high
//  din_valid   in   1      din carries a sample this cycle
//  din         in   IN_W   signed sample
//  dout        out  OUT_W  unsigned LL total over last NUM_WIN windows
//  dout_valid  out  1      one-cycle pulse: dout updated
//  filled      out  1      high once NUM_WIN windows have been collected
// BEHAVIOUR
//  - Accept: sample accepted on a rising edge when en==0 && din_valid==1 && clear==0.
//  - Reset (rst==0): async. Clears dout, dout_valid, filled, accumulator, counters and buffer. FSM->PRIME.
//  - clear==1 (en==0): same effect as reset at the next edge. The sample on that edge is discarded.
//  - Priority: rst > en-high freeze > clear > accept.
//  - en==1: every register holds and din_valid is ignored. dout_valid stays low; a pulse due that cycle is delayed, not lost.
//  - FSM states:
//    - PRIME: no previous sample. First accept stores prev, adds nothing, goes to FILL.
//    - FILL: fewer than NUM_WIN windows buffered. Goes to RUN when the NUM_WIN-th window is written.
//    - RUN: steady state. Leaves only via rst or clear.
//  - Per accept in FILL/RUN:
//    - d = |din - prev|, IN_W+1 bits unsigned, computed in IN_W+1 signed then magnitude. Never wraps.
//    - prev <= din; acc += d; sample count incremented.
//  - Window end (count hits WIN_LEN on an accept at edge E):
//    - At E: wsum = acc+d is written to buffer[wr_ptr]; acc and count reset to 0; wr_ptr advances modulo NUM_WIN.
//    - At E+1: total <= total + wsum - buffer_old.
//    - buffer_old is the entry overwritten at E; it is 0 while the buffer is not yet full.
//    - dout <= total; dout_valid pulses only if filled was already high or became high at E.
//    - Latency: 1 cycle from the window-closing accept to dout_valid.
//  - Pointer wrap: wr_ptr wraps NUM_WIN-1 -> 0, including non-power-of-2 NUM_WIN.
//  - Widths:
//    - ACC_W holds WIN_LEN*(2^(IN_W+1)-1); OUT_W holds NUM_WIN times that. No saturation needed.
//    - Subtraction never underflows because total always includes buffer_old.
//  - dout holds its value between pulses. filled stays high until rst/clear.
//  - din_valid gaps are allowed. Windows count accepted samples only, not cycles.
// TESTING  (bench params IN_W=16, WIN_LEN=4, NUM_WIN=2 -> ACC_W=19, OUT_W=20)
//  - Ramp din=0,1,2,...,16, one per cycle.
//    - After sample 8: dout=8, dout_valid pulse, filled=1.
//    - After sample 12: dout=8 again; after sample 16: dout=8.
//  - Alternating +100/-100 (prime +100, then 16 samples) -> dout=1600 at each window end from the 2nd window on.
//  - Alternating -32768/+32767 -> window=262140, dout=524280. No wrap.
//  - Ramp with din_valid low every other cycle, and en high for 3 cycles mid-window -> identical dout sequence to test 1.
//    During en high: no state change, no pulse.
//  - clear asserted after 6 ramp samples, then restart ramp from 0.
//    - filled drops to 0; the first pulse needs 9 fresh samples; dout=8.
//  - rst low mid-window for half a cycle -> all outputs 0 immediately (async). The next sample is treated as PRIME.

Source files
------------

// File: rtl/ll_window_if.sv
// Sample-side and result-side signals of the line-length window engine.
// The producer drives the master modport and the engine uses the slave modport.
interface ll_window_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 26
);
  logic             en;
  logic             clear;
  logic             din_valid;
  logic [IN_W-1:0]  din;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             filled;

  modport master (
    output en,
    output clear,
    output din_valid,
    output din,
    input  dout,
    input  dout_valid,
    input  filled
  );

  modport slave (
    input  en,
    input  clear,
    input  din_valid,
    input  din,
    output dout,
    output dout_valid,
    output filled
  );
endinterface

// File: rtl/ll_window_engine.sv
// Line-length feature engine: sums |x[n]-x[n-1]| per window of WIN_LEN accepted samples and
// keeps a running total over the last NUM_WIN windows (add newest, subtract evicted).
module ll_window_engine #(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned WIN_LEN = 50,
  parameter int unsigned NUM_WIN = 5
) (
  input logic        clk,
  input logic        rst,
  ll_window_if.slave bus
);
  localparam int unsigned ACC_W = IN_W + 1 + $clog2(WIN_LEN);
  localparam int unsigned OUT_W = ACC_W + $clog2(NUM_WIN);
  localparam int unsigned DW    = IN_W + 1;
  localparam int unsigned CNT_W = $clog2(WIN_LEN);
  localparam int unsigned PTR_W = $clog2(NUM_WIN);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIN_LEN - 1);
  localparam logic [PTR_W-1:0] PtrLast = PTR_W'(NUM_WIN - 1);

  typedef enum logic [1:0] {StPrime, StFill, StRun} state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  prev_q, prev_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [ACC_W-1:0] buf_q [NUM_WIN];
  logic [ACC_W-1:0] buf_d [NUM_WIN];
  logic [OUT_W-1:0] total_q, total_d;
  logic [ACC_W-1:0] wsum_q, wsum_d;
  logic [ACC_W-1:0] old_q, old_d;
  logic             pend_q, pend_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             filled_q, filled_d;

  logic signed [DW-1:0] diff;
  logic [DW-1:0]        mag;
  logic [ACC_W-1:0]     acc_sum;
  logic                 accept;

  // Sign-extend both operands so the difference of two extreme samples cannot wrap.
  assign diff    = $signed({bus.din[IN_W-1], bus.din}) - $signed({prev_q[IN_W-1], prev_q});
  assign mag     = diff[DW-1] ? DW'(-diff) : DW'(diff);
  assign acc_sum = acc_q + ACC_W'(mag);
  assign accept  = ~bus.en & bus.din_valid & ~bus.clear;

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    buf_d        = buf_q;
    total_d      = total_q;
    wsum_d       = wsum_q;
    old_d        = old_q;
    pend_d       = pend_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    filled_d     = filled_q;

    if (bus.en) begin
      // Frozen: everything holds, including a pending total update.
    end else if (bus.clear) begin
      state_d  = StPrime;
      prev_d   = '0;
      acc_d    = '0;
      cnt_d    = '0;
      ptr_d    = '0;
      buf_d    = '{default: '0};
      total_d  = '0;
      wsum_d   = '0;
      old_d    = '0;
      pend_d   = 1'b0;
      dout_d   = '0;
      filled_d = 1'b0;
    end else begin
      // Second half of a window close: retire the evicted sum, admit the new one.
      if (pend_q) begin
        total_d      = total_q + OUT_W'(wsum_q) - OUT_W'(old_q);
        dout_d       = total_d;
        dout_valid_d = filled_q;
        pend_d       = 1'b0;
      end

      if (accept) begin
        prev_d = bus.din;
        case (state_q)
          StPrime: state_d = StFill;
          default: begin
            if (cnt_q == CntLast) begin
              buf_d[ptr_q] = acc_sum;
              wsum_d       = acc_sum;
              old_d        = buf_q[ptr_q];
              pend_d       = 1'b1;
              acc_d        = '0;
              cnt_d        = '0;
              ptr_d        = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
              if (state_q == StFill && ptr_q == PtrLast) begin
                state_d  = StRun;
                filled_d = 1'b1;
              end
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StPrime;
      prev_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      buf_q        <= '{default: '0};
      total_q      <= '0;
      wsum_q       <= '0;
      old_q        <= '0;
      pend_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      filled_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      buf_q        <= buf_d;
      total_q      <= total_d;
      wsum_q       <= wsum_d;
      old_q        <= old_d;
      pend_q       <= pend_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      filled_q     <= filled_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.filled     = filled_q;
endmodule

// File: tb/tb_ll_window_engine.sv
// Directed bench for ll_window_engine with WIN_LEN=4, NUM_WIN=2 (dout is 20 bits wide).
module tb_ll_window_engine;
  localparam int unsigned IN_W    = 16;
  localparam int unsigned WIN_LEN = 4;
  localparam int unsigned NUM_WIN = 2;
  localparam int unsigned OUT_W   = 20;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  ll_window_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  ll_window_engine #(
    .IN_W   (IN_W),
    .WIN_LEN(WIN_LEN),
    .NUM_WIN(NUM_WIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic signed [IN_W-1:0] x);
    bus.din_valid = v;
    bus.din       = x;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.clear     = 1'b1;
    bus.din_valid = 1'b1;
    bus.din       = 16'd77;
    @(posedge clk);
    #1;
    bus.clear     = 1'b0;
    bus.din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_tests++; if (bus.dout !== 20'd0) begin n_fail++; $display("FAIL reset_dout: got %0d want 0", bus.dout); end
    n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", bus.dout_valid); end
    n_tests++; if (bus.filled !== 1'b0) begin n_fail++; $display("FAIL reset_filled: got %b want 0", bus.filled); end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 16'sd0);
    n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_dv: got %b want 0", bus.dout_valid); end
  endtask

  task automatic test_ramp();
    for (int k = 0; k <= 16; k++) begin
      drive(1'b1, 16'(k));
      n_tests++;
      if (bus.dout_valid !== (k == 9 || k == 13)) begin
        n_fail++; $display("FAIL ramp_dv k=%0d: got %b want %b", k, bus.dout_valid, (k == 9 || k == 13));
      end
      n_tests++;
      if (bus.filled !== (k >= 8)) begin
        n_fail++; $display("FAIL ramp_filled k=%0d: got %b want %b", k, bus.filled, (k >= 8));
      end
      if (k >= 9) begin
        n_tests++;
        if (bus.dout !== 20'd8) begin n_fail++; $display("FAIL ramp_dout k=%0d: got %0d want 8", k, bus.dout); end
      end
    end
    drive(1'b0, 16'sd0);
    n_tests++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL ramp_last_dv: got %b want 1", bus.dout_valid); end
    n_tests++; if (bus.dout !== 20'd8) begin n_fail++; $display("FAIL ramp_last_dout: got %0d want 8", bus.dout); end
    drive(1'b0, 16'sd0);
    n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_hold_dv: got %b want 0", bus.dout_valid); end
    n_tests++; if (bus.dout !== 20'd8) begin n_fail++; $display("FAIL ramp_hold_dout: got %0d want 8", bus.dout); end
  endtask

  task automatic test_alternating();
    do_clear();
    n_tests++; if (bus.dout !== 20'd0) begin n_fail++; $display("FAIL alt_clear_dout: got %0d want 0", bus.dout); end
    n_tests++; if (bus.filled !== 1'b0) begin n_fail++; $display("FAIL alt_clear_filled: got %b want 0", bus.filled); end
    drive(1'b1, 16'sd100);
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, (j % 2 == 0) ? -16'sd100 : 16'sd100);
      n_tests++;
      if (bus.dout_valid !== (j == 8 || j == 12)) begin
        n_fail++; $display("FAIL alt_dv j=%0d: got %b want %b", j, bus.dout_valid, (j == 8 || j == 12));
      end
      if (j == 4) begin
        n_tests++;
        if (bus.dout !== 20'd800) begin n_fail++; $display("FAIL alt_first_total: got %0d want 800", bus.dout); end
      end
      if (j == 8 || j == 12) begin
        n_tests++;
        if (bus.dout !== 20'd1600) begin n_fail++; $display("FAIL alt_dout j=%0d: got %0d want 1600", j, bus.dout); end
      end
    end
    drive(1'b0, 16'sd0);
    n_tests++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL alt_last_dv: got %b want 1", bus.dout_valid); end
    n_tests++; if (bus.dout !== 20'd1600) begin n_fail++; $display("FAIL alt_last_dout: got %0d want 1600", bus.dout); end
  endtask

  task automatic test_extremes();
    do_clear();
    drive(1'b1, -16'sd32768);
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, (j % 2 == 0) ? 16'sd32767 : -16'sd32768);
      n_tests++;
      if (bus.dout_valid !== (j == 8 || j == 12)) begin
        n_fail++; $display("FAIL ext_dv j=%0d: got %b want %b", j, bus.dout_valid, (j == 8 || j == 12));
      end
      if (j == 4) begin
        n_tests++;
        if (bus.dout !== 20'd262140) begin n_fail++; $display("FAIL ext_window: got %0d want 262140", bus.dout); end
      end
      if (j == 8 || j == 12) begin
        n_tests++;
        if (bus.dout !== 20'd524280) begin n_fail++; $display("FAIL ext_dout j=%0d: got %0d want 524280", j, bus.dout); end
      end
    end
    drive(1'b0, 16'sd0);
    n_tests++; if (bus.dout !== 20'd524280) begin n_fail++; $display("FAIL ext_last_dout: got %0d want 524280", bus.dout); end
  endtask

  task automatic test_gaps_freeze();
    do_clear();
    for (int k = 0; k <= 16; k++) begin
      drive(1'b1, 16'(k));
      n_tests++;
      if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL gap_accept_dv k=%0d: got %b want 0", k, bus.dout_valid); end
      if (k == 12) begin
        bus.en = 1'b1;
        for (int f = 0; f < 3; f++) begin
          drive(1'b1, 16'sd99);
          n_tests++;
          if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL freeze_dv f=%0d: got %b want 0", f, bus.dout_valid); end
          n_tests++;
          if (bus.dout !== 20'd8) begin n_fail++; $display("FAIL freeze_dout f=%0d: got %0d want 8", f, bus.dout); end
        end
        bus.en = 1'b0;
      end
      drive(1'b0, 16'sd555);
      n_tests++;
      if (bus.dout_valid !== (k == 8 || k == 12 || k == 16)) begin
        n_fail++; $display("FAIL gap_dv k=%0d: got %b want %b", k, bus.dout_valid, (k == 8 || k == 12 || k == 16));
      end
      if (k == 8 || k == 12 || k == 16) begin
        n_tests++;
        if (bus.dout !== 20'd8) begin n_fail++; $display("FAIL gap_dout k=%0d: got %0d want 8", k, bus.dout); end
      end
    end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 6; k++) drive(1'b1, 16'(k));
    n_tests++; if (bus.filled !== 1'b1) begin n_fail++; $display("FAIL clr_pre_filled: got %b want 1", bus.filled); end
    do_clear();
    n_tests++; if (bus.filled !== 1'b0) begin n_fail++; $display("FAIL clr_filled: got %b want 0", bus.filled); end
    n_tests++; if (bus.dout !== 20'd0) begin n_fail++; $display("FAIL clr_dout: got %0d want 0", bus.dout); end
    for (int k = 0; k <= 9; k++) begin
      drive(1'b1, 16'(k));
      n_tests++;
      if (bus.dout_valid !== (k == 9)) begin
        n_fail++; $display("FAIL clr_dv k=%0d: got %b want %b", k, bus.dout_valid, (k == 9));
      end
      n_tests++;
      if (bus.filled !== (k >= 8)) begin
        n_fail++; $display("FAIL clr_refill k=%0d: got %b want %b", k, bus.filled, (k >= 8));
      end
    end
    n_tests++; if (bus.dout !== 20'd8) begin n_fail++; $display("FAIL clr_dout_after: got %0d want 8", bus.dout); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'sd100);
    drive(1'b1, 16'sd101);
    bus.din_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    n_tests++; if (bus.dout !== 20'd0) begin n_fail++; $display("FAIL arst_dout: got %0d want 0", bus.dout); end
    n_tests++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL arst_dv: got %b want 0", bus.dout_valid); end
    n_tests++; if (bus.filled !== 1'b0) begin n_fail++; $display("FAIL arst_filled: got %b want 0", bus.filled); end
    #2 rst = 1'b1;
    drive(1'b1, 16'sd1000);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 16'(1000 + k));
      n_tests++;
      if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL arst_dv k=%0d: got %b want 0", k, bus.dout_valid); end
    end
    drive(1'b0, 16'sd0);
    n_tests++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pulse: got %b want 1", bus.dout_valid); end
    n_tests++; if (bus.dout !== 20'd8) begin n_fail++; $display("FAIL arst_prime_dout: got %0d want 8", bus.dout); end
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.clear     = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    test_reset();
    test_ramp();
    test_alternating();
    test_extremes();
    test_gaps_freeze();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
